// File: rtl/whack_pkg.sv
// whack_pkg: reporter state encoding and the 7-seg glyph table shared with the 7-seg driver.
package whack_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, SHOW, GAP} rep_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg7(input logic [3:0] d);
        return SEG_LUT[d];
    endfunction

endpackage

// File: rtl/score_reporter_if.sv
// score_reporter_if: game-core inputs and display/high-score outputs of the score reporter.
interface score_reporter_if;

    logic       game_end;
    logic [7:0] score;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic [7:0] hi_score;
    logic       new_record;

    modport master (output game_end, score, input seg, dp, busy, hi_score, new_record);
    modport slave  (input game_end, score, output seg, dp, busy, hi_score, new_record);

endinterface

// File: rtl/score_reporter_bin2bcd_seq.sv
// bin2bcd_seq: 8-iteration double-dabble converter; done is high during the last step with bcd valid.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [19:0] sh, adj, nxt;
    logic [2:0]  iter;
    logic        run;

    always_comb begin
        adj = sh;
        for (int i = 0; i < 3; i++)
            adj[8 + 4 * i +: 4] = sh[8 + 4 * i +: 4] >= 4'd5 ? sh[8 + 4 * i +: 4] + 4'd3 : sh[8 + 4 * i +: 4];
        nxt = {adj[18:0], 1'b0};
    end

    assign busy = run;
    assign done = run && iter == 3'd7;
    assign bcd  = nxt[19:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run  <= 1'b0;
            iter <= '0;
            sh   <= '0;
        end else if (start) begin
            run  <= 1'b1;
            iter <= '0;
            sh   <= {12'b0, bin};
        end else if (abort) begin
            run  <= 1'b0;
        end else if (run) begin
            sh   <= nxt;
            iter <= iter + 3'd1;
            run  <= iter != 3'd7;
        end
    end

endmodule

// File: rtl/score_reporter.sv
// score_reporter: BCD-converts the final score and scrolls its digits on one 7-seg display.
// Define HISCORE_REPORT_EN to keep a session high score and light dp on a new record.
module score_reporter
    import whack_pkg::*;
#(
    parameter int DIGIT_CYCLES = 6_000_000,
    parameter int GAP_CYCLES   = 3_000_000
) (
    input logic             clk,
    input logic             rst_n,
    score_reporter_if.slave sr
);

    localparam int CNT_MAX = DIGIT_CYCLES > GAP_CYCLES ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    rep_state_t      state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      idx, idx_n;
    logic [2:0][3:0] digs;
    logic [11:0]     bcd;
    logic            ge_q, start, abort, done, fin;

    // Index of the first digit to show: H, then T, else the ones digit always shows.
    function automatic logic [1:0] lead(input logic [11:0] d);
        return d[11:8] != 4'd0 ? 2'd2 : d[7:4] != 4'd0 ? 2'd1 : 2'd0;
    endfunction

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .bin   (sr.score),
        .busy  (sr.busy),
        .done  (done),
        .bcd   (bcd)
    );

    assign abort = state == CONVERT && !sr.game_end;
    assign fin   = state == CONVERT && sr.game_end && done;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = '0;
        start   = 1'b0;
        case (state)
            IDLE: begin
                start   = sr.game_end && !ge_q;
                state_n = start ? CONVERT : IDLE;
            end
            CONVERT: begin
                state_n = !sr.game_end ? IDLE : done ? SHOW : CONVERT;
                idx_n   = lead(bcd);
            end
            SHOW: begin
                if (!sr.game_end) state_n = IDLE;
                else if (cnt != CW'(DIGIT_CYCLES - 1)) cnt_n = cnt + 1'b1;
                else if (idx == 2'd0) state_n = GAP;
                else idx_n = idx - 2'd1;
            end
            GAP: begin
                if (!sr.game_end) state_n = IDLE;
                else if (cnt != CW'(GAP_CYCLES - 1)) cnt_n = cnt + 1'b1;
                else begin
                    state_n = SHOW;
                    idx_n   = lead(digs);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ge_q resets high so a game_end held through reset is not taken as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            digs  <= '0;
            ge_q  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            ge_q  <= sr.game_end;
            if (fin) digs <= bcd;
        end
    end

    assign sr.seg = state == SHOW ? seg7(digs[idx]) : SEG_BLANK;

`ifdef HISCORE_REPORT_EN
    logic [7:0] score_q, hi_q;
    logic       rec_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_q <= '0;
            hi_q    <= '0;
            rec_q   <= 1'b0;
        end else if (start) begin
            score_q <= sr.score;
            rec_q   <= 1'b0;
        end else if (fin && score_q > hi_q) begin
            hi_q    <= score_q;
            rec_q   <= 1'b1;
        end
    end

    assign sr.hi_score   = hi_q;
    assign sr.new_record = rec_q;
    assign sr.dp         = !(state == SHOW && rec_q);
`else
    assign sr.hi_score   = 8'h00;
    assign sr.new_record = 1'b0;
    assign sr.dp         = 1'b1;
`endif

endmodule

// File: tb/tb_score_reporter.sv
// tb_score_reporter: randomized games against a schedule-based reference model, checked by a queue scoreboard.
module tb_score_reporter;

    localparam int DC = 8;
    localparam int GC = 4;
`ifdef HISCORE_REPORT_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif
    localparam logic [6:0] SEG_REF [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic       busy;
        logic [7:0] hi;
        logic       rec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    score_reporter_if sr();

    score_reporter #(.DIGIT_CYCLES(DC), .GAP_CYCLES(GC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sr    (sr)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    exp_t       got_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc_n  = 0;
    bit         m_idle = 1'b1;
    bit         m_prev = 1'b1;
    bit         m_rec  = 1'b0;
    int         m_t    = 0;
    int         m_s    = 0;
    int         m_hi   = 0;
    int         dig[$];

    // Expected outputs from time since capture: 8 busy clocks, then digit slots and a gap, repeating.
    function automatic exp_t expect_now();
        exp_t e;
        int n, u;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.busy = 1'b0;
        e.hi   = HS ? 8'(m_hi) : 8'h00;
        e.rec  = HS && m_rec;
        if (!m_idle && m_t <= 8) e.busy = 1'b1;
        else if (!m_idle) begin
            n = dig.size();
            u = (m_t - 9) % (DC * n + GC);
            if (u < DC * n) begin
                e.seg = SEG_REF[dig[u / DC]];
                e.dp  = !(HS && m_rec);
            end
        end
        return e;
    endfunction

    task automatic step(input bit ge, input logic [7:0] sc, input bit rn);
        @(negedge clk);
        sr.game_end = ge;
        sr.score    = sc;
        rst_n       = rn;
        if (!rn) begin
            m_idle = 1'b1;
            m_hi   = 0;
            m_rec  = 1'b0;
            m_prev = 1'b1;
        end else begin
            if (m_idle) begin
                if (ge && !m_prev) begin
                    m_idle = 1'b0;
                    m_t    = 1;
                    m_s    = int'(sc);
                    m_rec  = 1'b0;
                    dig.delete();
                    if (m_s >= 100) dig.push_back(m_s / 100);
                    if (m_s >= 10) dig.push_back((m_s / 10) % 10);
                    dig.push_back(m_s % 10);
                end
            end else if (!ge) m_idle = 1'b1;
            else begin
                m_t++;
                if (m_t == 9 && m_s > m_hi) begin
                    m_hi  = m_s;
                    m_rec = 1'b1;
                end
            end
            m_prev = ge;
        end
        exp_q.push_back(expect_now());
    endtask

    task automatic game(input logic [7:0] s, input int n, input int idle_n, input bit noisy);
        for (int i = 0; i < n; i++) step(1'b1, (i == 0 || !noisy) ? s : 8'($urandom), 1'b1);
        for (int i = 0; i < idle_n; i++) step(1'b0, 8'($urandom), 1'b1);
    endtask

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc_n, a, e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            cyc_n++;
            chk("seg", {1'b0, sr.seg}, {1'b0, got_e.seg});
            chk("dp", {7'b0, sr.dp}, {7'b0, got_e.dp});
            chk("busy", {7'b0, sr.busy}, {7'b0, got_e.busy});
            chk("hi_score", sr.hi_score, got_e.hi);
            chk("new_record", {7'b0, sr.new_record}, {7'b0, got_e.rec});
        end
    end

    initial begin
        sr.game_end = 1'b0;
        sr.score    = 8'd0;
        repeat (2) step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        game(8'd42, 8 + 2 * (2 * DC + GC) + 3, 2, 1'b1);
        game(8'd255, 8 + 3 * DC + GC + 2 * DC, 2, 1'b0);
        game(8'd0, 8 + DC + GC + DC + 1, 2, 1'b0);
        game(8'd7, 8 + DC + GC + 2, 2, 1'b0);
        game(8'd50, 8 + 2 * DC + GC, 2, 1'b0);
        game(8'd30, 30, 2, 1'b0);
        game(8'd50, 30, 2, 1'b0);
        game(8'd99, 4, 2, 1'b0);
        game(8'd120, 15, 0, 1'b0);
        step(1'b1, 8'd77, 1'b0);
        repeat (10) step(1'b1, 8'd77, 1'b1);
        repeat (2) step(1'b0, 8'd0, 1'b1);
        game(8'd200, 30, 2, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            game(8'($urandom), $urandom_range(1, 70), $urandom_range(1, 4), 1'b1);
        end
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
